// File: rtl/zcash_fpga_pkg.sv
// Shared command codes, packet layouts and reply builders for the Zcash FPGA host interface.
// Replies are packed LSB-first, so the header_t field sits in the lowest 64 bits.
package zcash_fpga_pkg;

  localparam int FPGA_STATUS_BEATS = 5;
  localparam int RPL_BEATS_MAX     = 5;
  localparam int RPL_W             = RPL_BEATS_MAX * 64;

  localparam logic [63:0] FPGA_CMD_CAP = 64'h0000_0000_0000_0007;
  localparam logic [31:0] FPGA_VERSION = 32'h0000_0001;

  typedef enum logic [31:0] {
    RESET_FPGA          = 32'h0000_0000,
    FPGA_STATUS         = 32'h0000_0001,
    VERIFY_EQUIHASH     = 32'h0000_0100,
    RESET_FPGA_RPL      = 32'h8000_0000,
    FPGA_STATUS_RPL     = 32'h8000_0001,
    FPGA_IGNORE_RPL     = 32'h8000_0002,
    VERIFY_EQUIHASH_RPL = 32'h8000_0100
  } command_t;

  typedef enum logic [2:0] {
    IDLE       = 3'd0,
    FWD_EQ     = 3'd1,
    DROP       = 3'd2,
    RPL_RESET  = 3'd3,
    RPL_STATUS = 3'd4,
    RPL_IGNORE = 3'd5
  } typ1_state_t;

  typedef struct packed {
    logic [31:0] cmd;
    logic [31:0] len;
  } header_t;

  typedef struct packed {
    logic [3:0]  padding;
    typ1_state_t typ1_state;
    logic        error;
  } fpga_state_t;

  typedef struct packed {
    header_t ignore_hdr;
    header_t hdr;
  } fpga_ignore_rpl_t;

  typedef struct packed {
    fpga_state_t fpga_state;
    logic [63:0] build_date;
    logic [63:0] build_host;
    logic [31:0] version;
    logic [63:0] cmd_cap;
    header_t     hdr;
  } fpga_status_rpl_t;

  function automatic header_t get_fpga_reset_rpl();
    header_t h;
    h.cmd = RESET_FPGA_RPL;
    h.len = 32'd8;
    return h;
  endfunction

  function automatic fpga_ignore_rpl_t get_fpga_ignore_rpl(input header_t hdr);
    fpga_ignore_rpl_t r;
    r.hdr.cmd    = FPGA_IGNORE_RPL;
    r.hdr.len    = 32'($bits(fpga_ignore_rpl_t) / 8);
    r.ignore_hdr = hdr;
    return r;
  endfunction

  function automatic fpga_status_rpl_t get_fpga_status_rpl(input logic [63:0] build_host,
                                                           input logic [63:0] build_date,
                                                           input fpga_state_t fpga_state);
    fpga_status_rpl_t r;
    r.hdr.cmd    = FPGA_STATUS_RPL;
    r.hdr.len    = 32'($bits(fpga_status_rpl_t) / 8);
    r.cmd_cap    = FPGA_CMD_CAP;
    r.version    = FPGA_VERSION;
    r.build_host = build_host;
    r.build_date = build_date;
    r.fpga_state = fpga_state;
    return r;
  endfunction

  // Beat idx of a header-first reply held zero-extended in an RPL_W vector.
  function automatic logic [63:0] get_rpl_beat(input logic [RPL_W-1:0] rpl, input logic [2:0] idx);
    logic [RPL_W-1:0] shifted;
    shifted = rpl >> {idx, 6'd0};
    return shifted[63:0];
  endfunction

endpackage

// File: rtl/zcash_fpga_rpl_arb.sv
// Two-input reply arbiter: grants only at packet boundaries (input a has priority)
// and drives a registered output stage that holds data while the sink stalls.
module zcash_fpga_rpl_arb (
  input  logic        clk,
  input  logic        rst,
  input  logic        en,
  input  logic [63:0] a_dat,
  input  logic        a_val,
  input  logic        a_sop,
  input  logic        a_eop,
  input  logic [2:0]  a_mod,
  output logic        a_rdy,
  input  logic [63:0] b_dat,
  input  logic        b_val,
  input  logic        b_sop,
  input  logic        b_eop,
  input  logic [2:0]  b_mod,
  output logic        b_rdy,
  output logic [63:0] tx_dat,
  output logic        tx_val,
  output logic        tx_sop,
  output logic        tx_eop,
  output logic [2:0]  tx_mod,
  input  logic        tx_rdy
);

  logic        act;
  logic        sel_q;
  logic        sel;
  logic [63:0] in_dat;
  logic        in_val;
  logic        in_sop;
  logic        in_eop;
  logic [2:0]  in_mod;
  logic        load;

  always_comb begin
    sel = act ? sel_q : !a_val;
    if (sel) begin
      in_dat = b_dat; in_val = b_val; in_sop = b_sop; in_eop = b_eop; in_mod = b_mod;
    end else begin
      in_dat = a_dat; in_val = a_val; in_sop = a_sop; in_eop = a_eop; in_mod = a_mod;
    end
  end

  assign a_rdy = en && tx_rdy && !sel;
  assign b_rdy = en && tx_rdy && sel;
  assign load  = en && tx_rdy && in_val;

  // Grant is held from the first accepted beat until the eop beat is taken.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      act    <= 1'b0;
      sel_q  <= 1'b0;
      tx_val <= 1'b0;
    end else if (en && tx_rdy) begin
      tx_val <= in_val;
      if (in_val) begin
        act   <= !in_eop;
        sel_q <= sel;
      end
    end
  end

  always_ff @(posedge clk) begin
    if (load) begin
      tx_dat <= in_dat;
      tx_sop <= in_sop;
      tx_eop <= in_eop;
      tx_mod <= in_mod;
    end
  end

endmodule

// File: rtl/zcash_fpga_cmd_ctrl.sv
// Host command controller: decodes host packets, answers reset/status/unknown commands
// locally, forwards equihash packets and merges all replies onto the host reply stream.
module zcash_fpga_cmd_ctrl
  import zcash_fpga_pkg::*;
#(
  parameter int DAT_BYTS      = 8,
  parameter int RST_PULSE_CYC = 16
) (
  input  logic                  i_clk,
  input  logic                  i_rst,
  input  logic [63:0]           i_build_host,
  input  logic [63:0]           i_build_date,
  input  logic [DAT_BYTS*8-1:0] i_rx_dat,
  input  logic                  i_rx_val,
  input  logic                  i_rx_sop,
  input  logic                  i_rx_eop,
  input  logic [2:0]            i_rx_mod,
  output logic                  o_rx_rdy,
  output logic [DAT_BYTS*8-1:0] o_eq_dat,
  output logic                  o_eq_val,
  output logic                  o_eq_sop,
  output logic                  o_eq_eop,
  output logic [2:0]            o_eq_mod,
  input  logic                  i_eq_rdy,
  input  logic [DAT_BYTS*8-1:0] i_eqr_dat,
  input  logic                  i_eqr_val,
  input  logic                  i_eqr_sop,
  input  logic                  i_eqr_eop,
  input  logic [2:0]            i_eqr_mod,
  output logic                  o_eqr_rdy,
  output logic [DAT_BYTS*8-1:0] o_tx_dat,
  output logic                  o_tx_val,
  output logic                  o_tx_sop,
  output logic                  o_tx_eop,
  output logic [2:0]            o_tx_mod,
  input  logic                  i_tx_rdy,
  output logic                  o_reset_fpga,
  output logic [7:0]            o_fpga_state
);

  localparam int          RST_CNT_W  = $clog2(RST_PULSE_CYC + 1);
  localparam logic [2:0]  STATUS_MOD = 3'(($bits(fpga_status_rpl_t) / 8) % 8);

  typ1_state_t          state, state_nxt;
  fpga_state_t          fpga_state;
  header_t              rx_hdr;
  logic                 run;
  logic                 err;
  logic                 err_set;
  logic                 is_eq_hdr;
  logic                 idle_rdy;
  logic                 rx_acc;
  logic                 cnt_load;
  logic                 hdr_eop;
  logic [31:0]          byte_cnt;
  logic [31:0]          len_q;
  logic [31:0]          beat_byts;
  logic [31:0]          cnt_sum;
  logic                 rst_start;
  logic [RST_CNT_W-1:0] rst_cnt;
  logic                 rpl_load;
  logic [RPL_W-1:0]     rpl_nxt;
  logic [2:0]           rpl_beats_nxt;
  logic [2:0]           rpl_mod_nxt;
  logic                 rpl_val;
  logic [2:0]           rpl_idx;
  logic [2:0]           rpl_beats;
  logic [2:0]           rpl_mod;
  logic [RPL_W-1:0]     rpl_dat;
  logic [63:0]          lcl_dat;
  logic                 lcl_sop;
  logic                 lcl_eop;
  logic [2:0]           lcl_mod;
  logic                 lcl_rdy;

  assign rx_hdr       = i_rx_dat;
  assign fpga_state   = '{padding: 4'd0, typ1_state: state, error: err};
  assign o_fpga_state = fpga_state;
  assign is_eq_hdr    = i_rx_sop && (rx_hdr.cmd == VERIFY_EQUIHASH);
  assign beat_byts    = (i_rx_eop && i_rx_mod != 3'd0) ? {29'd0, i_rx_mod} : 32'd8;
  assign cnt_sum      = byte_cnt + beat_byts;

  assign o_eq_dat = i_rx_dat;
  assign o_eq_sop = i_rx_sop;
  assign o_eq_eop = i_rx_eop;
  assign o_eq_mod = i_rx_mod;

  always_comb begin
    state_nxt     = state;
    o_rx_rdy      = 1'b0;
    o_eq_val      = 1'b0;
    idle_rdy      = 1'b0;
    rx_acc        = 1'b0;
    cnt_load      = 1'b0;
    err_set       = 1'b0;
    rst_start     = 1'b0;
    rpl_load      = 1'b0;
    rpl_nxt       = '0;
    rpl_beats_nxt = 3'd1;
    rpl_mod_nxt   = 3'd0;
    case (state)
      IDLE: begin
        // An equihash header is peeked so it can pass straight through to the verifier.
        if (run && !rpl_val) begin
          idle_rdy = !is_eq_hdr || i_eq_rdy;
          o_rx_rdy = idle_rdy;
          o_eq_val = i_rx_val && is_eq_hdr;
          if (i_rx_val && idle_rdy) begin
            cnt_load = 1'b1;
            if (!i_rx_sop) begin
              err_set = 1'b1;
              if (!i_rx_eop) state_nxt = DROP;
            end else if (rx_hdr.cmd == VERIFY_EQUIHASH) begin
              if (!i_rx_eop) state_nxt = FWD_EQ;
            end else begin
              rpl_load = 1'b1;
              if (rx_hdr.cmd == RESET_FPGA) begin
                state_nxt     = RPL_RESET;
                rst_start     = 1'b1;
                rpl_nxt[63:0] = get_fpga_reset_rpl();
              end else if (rx_hdr.cmd == FPGA_STATUS) begin
                state_nxt     = RPL_STATUS;
                rpl_nxt[$bits(fpga_status_rpl_t)-1:0] =
                  get_fpga_status_rpl(i_build_host, i_build_date, fpga_state);
                rpl_beats_nxt = 3'(FPGA_STATUS_BEATS);
                rpl_mod_nxt   = STATUS_MOD;
              end else begin
                state_nxt      = RPL_IGNORE;
                rpl_nxt[127:0] = get_fpga_ignore_rpl(rx_hdr);
                rpl_beats_nxt  = 3'd2;
              end
            end
          end
        end
      end
      FWD_EQ: begin
        o_rx_rdy = i_eq_rdy;
        o_eq_val = i_rx_val;
        rx_acc   = i_rx_val && i_eq_rdy;
        if (rx_acc && i_rx_eop) state_nxt = IDLE;
      end
      DROP: begin
        o_rx_rdy = 1'b1;
        rx_acc   = i_rx_val;
        if (rx_acc && i_rx_eop) state_nxt = IDLE;
      end
      default: state_nxt = hdr_eop ? IDLE : DROP;
    endcase
    if (rx_acc && (i_rx_eop ? (cnt_sum != len_q) : (cnt_sum > len_q))) err_set = 1'b1;
  end

  always_ff @(posedge i_clk or posedge i_rst) begin
    if (i_rst) state <= IDLE;
    else       state <= state_nxt;
  end

  // Control: ready enable, sticky error, reset pulse and local reply sequencing.
  always_ff @(posedge i_clk or posedge i_rst) begin
    if (i_rst) begin
      run          <= 1'b0;
      err          <= 1'b0;
      rst_cnt      <= '0;
      o_reset_fpga <= 1'b0;
      rpl_val      <= 1'b0;
      rpl_idx      <= 3'd0;
    end else begin
      run <= 1'b1;
      if (err_set) err <= 1'b1;
      if (rst_start) begin
        o_reset_fpga <= 1'b1;
        rst_cnt      <= RST_CNT_W'(RST_PULSE_CYC - 1);
      end else if (rst_cnt != '0) begin
        rst_cnt <= rst_cnt - RST_CNT_W'(1);
      end else begin
        o_reset_fpga <= 1'b0;
      end
      if (rpl_load) begin
        rpl_val <= 1'b1;
        rpl_idx <= 3'd0;
      end else if (rpl_val && lcl_rdy) begin
        if (lcl_eop) rpl_val <= 1'b0;
        else         rpl_idx <= rpl_idx + 3'd1;
      end
    end
  end

  always_ff @(posedge i_clk) begin
    if (cnt_load) begin
      byte_cnt <= 32'd8;
      len_q    <= rx_hdr.len;
      hdr_eop  <= i_rx_eop;
    end else if (rx_acc) begin
      byte_cnt <= cnt_sum;
    end
    if (rpl_load) begin
      rpl_dat   <= rpl_nxt;
      rpl_beats <= rpl_beats_nxt;
      rpl_mod   <= rpl_mod_nxt;
    end
  end

  assign lcl_dat = get_rpl_beat(rpl_dat, rpl_idx);
  assign lcl_sop = (rpl_idx == 3'd0);
  assign lcl_eop = (rpl_idx == rpl_beats - 3'd1);
  assign lcl_mod = lcl_eop ? rpl_mod : 3'd0;

  zcash_fpga_rpl_arb u_rpl_arb (
    .clk    (i_clk),
    .rst    (i_rst),
    .en     (run),
    .a_dat  (lcl_dat),
    .a_val  (rpl_val),
    .a_sop  (lcl_sop),
    .a_eop  (lcl_eop),
    .a_mod  (lcl_mod),
    .a_rdy  (lcl_rdy),
    .b_dat  (i_eqr_dat),
    .b_val  (i_eqr_val),
    .b_sop  (i_eqr_sop),
    .b_eop  (i_eqr_eop),
    .b_mod  (i_eqr_mod),
    .b_rdy  (o_eqr_rdy),
    .tx_dat (o_tx_dat),
    .tx_val (o_tx_val),
    .tx_sop (o_tx_sop),
    .tx_eop (o_tx_eop),
    .tx_mod (o_tx_mod),
    .tx_rdy (i_tx_rdy)
  );

endmodule

// File: tb/tb_zcash_fpga_cmd_ctrl.sv
// Scoreboard bench for zcash_fpga_cmd_ctrl: expected reply and forwarded beats are queued
// as stimulus is driven and compared as the DUT hands them off.
module tb_zcash_fpga_cmd_ctrl;

  logic        clk = 1'b0;
  logic        rst;
  logic [63:0] i_build_host, i_build_date;
  logic [63:0] i_rx_dat;
  logic        i_rx_val, i_rx_sop, i_rx_eop;
  logic [2:0]  i_rx_mod;
  logic        o_rx_rdy;
  logic [63:0] o_eq_dat;
  logic        o_eq_val, o_eq_sop, o_eq_eop;
  logic [2:0]  o_eq_mod;
  logic        i_eq_rdy;
  logic [63:0] i_eqr_dat;
  logic        i_eqr_val, i_eqr_sop, i_eqr_eop;
  logic [2:0]  i_eqr_mod;
  logic        o_eqr_rdy;
  logic [63:0] o_tx_dat;
  logic        o_tx_val, o_tx_sop, o_tx_eop;
  logic [2:0]  o_tx_mod;
  logic        i_tx_rdy;
  logic        o_reset_fpga;
  logic [7:0]  o_fpga_state;

  int n_chk = 0;
  int n_err = 0;
  int rst_hi = 0;
  int eqr_acc = 0;
  bit eq_rand = 0;
  bit tx_rand = 0;
  logic [68:0] tx_q[$];
  logic [68:0] eq_q[$];

  always #5 clk = ~clk;

  zcash_fpga_cmd_ctrl #(.DAT_BYTS(8), .RST_PULSE_CYC(16)) dut (
    .i_clk(clk), .i_rst(rst),
    .i_build_host(i_build_host), .i_build_date(i_build_date),
    .i_rx_dat(i_rx_dat), .i_rx_val(i_rx_val), .i_rx_sop(i_rx_sop), .i_rx_eop(i_rx_eop),
    .i_rx_mod(i_rx_mod), .o_rx_rdy(o_rx_rdy),
    .o_eq_dat(o_eq_dat), .o_eq_val(o_eq_val), .o_eq_sop(o_eq_sop), .o_eq_eop(o_eq_eop),
    .o_eq_mod(o_eq_mod), .i_eq_rdy(i_eq_rdy),
    .i_eqr_dat(i_eqr_dat), .i_eqr_val(i_eqr_val), .i_eqr_sop(i_eqr_sop), .i_eqr_eop(i_eqr_eop),
    .i_eqr_mod(i_eqr_mod), .o_eqr_rdy(o_eqr_rdy),
    .o_tx_dat(o_tx_dat), .o_tx_val(o_tx_val), .o_tx_sop(o_tx_sop), .o_tx_eop(o_tx_eop),
    .o_tx_mod(o_tx_mod), .i_tx_rdy(i_tx_rdy),
    .o_reset_fpga(o_reset_fpga), .o_fpga_state(o_fpga_state)
  );

  task automatic check_eq(input string tag, input logic [127:0] got, input logic [127:0] exp);
    n_chk++;
    if (got !== exp) begin
      n_err++;
      $display("FAIL %s got=%0h exp=%0h", tag, got, exp);
    end
  endtask

  // Handshakes are sampled on the falling edge; inputs only move just after the rising edge.
  initial forever begin
    @(negedge clk);
    if (o_reset_fpga) rst_hi++;
    if (i_eqr_val && o_eqr_rdy) eqr_acc++;
    if (o_tx_val && i_tx_rdy) begin
      if (tx_q.size() == 0) check_eq("tx_unexpected", {59'd0, o_tx_sop, o_tx_eop, o_tx_mod, o_tx_dat}, 128'd0);
      else check_eq("tx_beat", {o_tx_sop, o_tx_eop, o_tx_mod, o_tx_dat}, tx_q.pop_front());
    end
    if (o_eq_val && i_eq_rdy) begin
      if (eq_q.size() == 0) check_eq("eq_unexpected", {59'd0, o_eq_sop, o_eq_eop, o_eq_mod, o_eq_dat}, 128'd0);
      else check_eq("eq_beat", {o_eq_sop, o_eq_eop, o_eq_mod, o_eq_dat}, eq_q.pop_front());
    end
  end

  initial forever begin
    @(posedge clk); #1;
    i_eq_rdy = eq_rand ? 1'($urandom_range(0, 1)) : 1'b1;
    i_tx_rdy = tx_rand ? 1'($urandom_range(0, 1)) : 1'b1;
  end

  initial begin
    #500000;
    $display("FAIL watchdog got=timeout exp=finish");
    $fatal(1, "watchdog");
  end

  task automatic cycles(input int n);
    repeat (n) begin @(posedge clk); #1; end
  endtask

  task automatic rx_send(input logic [63:0] d, input logic sop, input logic eop, input logic [2:0] mod);
    int  t;
    logic hs;
    t = 0; hs = 1'b0;
    i_rx_dat = d; i_rx_sop = sop; i_rx_eop = eop; i_rx_mod = mod; i_rx_val = 1'b1;
    while (!hs && t < 1000) begin
      @(negedge clk); hs = o_rx_rdy;
      @(posedge clk); #1; t++;
    end
    i_rx_val = 1'b0;
    if (!hs) check_eq("rx_timeout", t, 0);
  endtask

  task automatic send_pkt(input logic [63:0] hdr, input int nbeats, input logic [2:0] last_mod, input bit fwd);
    logic [63:0] d;
    logic        sop, eop;
    logic [2:0]  mod;
    for (int i = 0; i < nbeats; i++) begin
      d   = (i == 0) ? hdr : {$urandom, $urandom};
      sop = (i == 0);
      eop = (i == nbeats - 1);
      mod = eop ? last_mod : 3'd0;
      if (fwd) eq_q.push_back({sop, eop, mod, d});
      rx_send(d, sop, eop, mod);
    end
  endtask

  task automatic push_status(input logic [63:0] host, input logic [63:0] date, input logic err);
    logic [319:0] v;
    v = {24'd0, 7'd0, err, date, host, 32'h0000_0001, 64'h7, 32'h8000_0001, 32'd37};
    for (int i = 0; i < 5; i++)
      tx_q.push_back({i == 0, i == 4, (i == 4) ? 3'd5 : 3'd0, v[i*64 +: 64]});
  endtask

  task automatic eqr_send(input int n);
    logic [68:0] beats[$];
    logic [63:0] d;
    int t;
    logic hs;
    for (int i = 0; i < n; i++) begin
      d = (i == 0) ? 64'h80000100_00000050 : {$urandom, $urandom};
      beats.push_back({i == 0, i == n - 1, 3'd0, d});
      tx_q.push_back({i == 0, i == n - 1, 3'd0, d});
    end
    foreach (beats[i]) begin
      {i_eqr_sop, i_eqr_eop, i_eqr_mod, i_eqr_dat} = beats[i];
      i_eqr_val = 1'b1;
      t = 0; hs = 1'b0;
      while (!hs && t < 1000) begin
        @(negedge clk); hs = o_eqr_rdy;
        @(posedge clk); #1; t++;
      end
      if (!hs) check_eq("eqr_timeout", t, 0);
    end
    i_eqr_val = 1'b0;
  endtask

  task automatic drain();
    int t;
    t = 0;
    while ((tx_q.size() != 0 || eq_q.size() != 0) && t < 5000) begin cycles(1); t++; end
    cycles(4);
    check_eq("drain_tx", tx_q.size(), 0);
    check_eq("drain_eq", eq_q.size(), 0);
  endtask

  initial begin
    int t;
    rst = 1'b1;
    i_build_host = 64'h1122334455667788;
    i_build_date = 64'h0000_0000_2019_0612;
    i_rx_dat = '0; i_rx_val = 1'b0; i_rx_sop = 1'b0; i_rx_eop = 1'b0; i_rx_mod = '0;
    i_eqr_dat = '0; i_eqr_val = 1'b0; i_eqr_sop = 1'b0; i_eqr_eop = 1'b0; i_eqr_mod = '0;
    i_eq_rdy = 1'b1; i_tx_rdy = 1'b1;
    cycles(4);
    check_eq("rst_tx_val", o_tx_val, 0);
    check_eq("rst_eq_val", o_eq_val, 0);
    check_eq("rst_rx_rdy", o_rx_rdy, 0);
    check_eq("rst_eqr_rdy", o_eqr_rdy, 0);
    check_eq("rst_reset_fpga", o_reset_fpga, 0);
    check_eq("rst_fpga_state", o_fpga_state, 0);
    rst = 1'b0;
    cycles(3);
    check_eq("idle_rx_rdy", o_rx_rdy, 1);

    // Status request, error clear.
    push_status(i_build_host, i_build_date, 1'b0);
    send_pkt(64'h00000001_00000008, 1, 3'd0, 0);
    drain();

    // Soft reset pulse and its one-beat reply.
    rst_hi = 0;
    tx_q.push_back({1'b1, 1'b1, 3'd0, 64'h80000000_00000008});
    send_pkt(64'h00000000_00000008, 1, 3'd0, 0);
    drain();
    cycles(20);
    check_eq("reset_pulse_len", rst_hi, 16);

    // Well-formed equihash packet under verifier backpressure.
    eq_rand = 1;
    send_pkt(64'h00000100_000005D7, 187, 3'd7, 1);
    drain();
    eq_rand = 0;
    check_eq("eq_no_err", o_fpga_state[0], 0);
    check_eq("eq_back_idle", o_fpga_state[3:1], 0);

    // Unknown command: 2-beat ignore reply, trailing beats dropped.
    tx_q.push_back({1'b1, 1'b0, 3'd0, 64'h80000002_00000010});
    tx_q.push_back({1'b0, 1'b1, 3'd0, 64'h00000505_00000018});
    send_pkt(64'h00000505_00000018, 3, 3'd0, 0);
    drain();
    check_eq("ign_no_err", o_fpga_state[0], 0);
    check_eq("ign_back_idle", o_fpga_state[3:1], 0);

    // Truncated equihash packet sets the sticky error.
    send_pkt(64'h00000100_000005D7, 100, 3'd0, 1);
    drain();
    check_eq("trunc_err", o_fpga_state[0], 1);
    cycles(10);
    check_eq("trunc_err_sticky", o_fpga_state[0], 1);
    push_status(i_build_host, i_build_date, 1'b1);
    send_pkt(64'h00000001_00000008, 1, 3'd0, 0);
    drain();

    // Status request while a verifier reply is mid-packet under host backpressure.
    tx_rand = 1;
    eqr_acc = 0;
    fork
      eqr_send(10);
      begin
        t = 0;
        while (eqr_acc < 3 && t < 1000) begin cycles(1); t++; end
        check_eq("eqr_started", eqr_acc >= 3, 1);
        push_status(i_build_host, i_build_date, 1'b1);
        send_pkt(64'h00000001_00000008, 1, 3'd0, 0);
      end
    join
    drain();
    tx_rand = 0;
    check_eq("final_err", o_fpga_state[0], 1);

    $display("Result: errors=%0d of %0d checks", n_err, n_chk);
    $finish;
  end

endmodule
